// File: rtl/pc_recovery_ctrl_if.sv
// Voter-side and core-side signals of the PC rollback/recovery controller.
// The controller is the slave; whoever drives the voter signals is the master.
interface pc_recovery_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int FCNT_W = 8
);
  logic [2:0]        voter_state;
  logic [XLEN-1:0]   pc_voter_output;
  logic              pc_valid;
  logic [XLEN-1:0]   pc_top;
  logic              recovery_data_memwrite_sel;
  logic              data_recovery_sel;
  logic              recovery_busy;
  logic              recovery_fail;
  logic [FCNT_W-1:0] fault_count;

  modport master (
    output voter_state, pc_voter_output, pc_valid,
    input  pc_top, recovery_data_memwrite_sel, data_recovery_sel,
    input  recovery_busy, recovery_fail, fault_count
  );

  modport slave (
    input  voter_state, pc_voter_output, pc_valid,
    output pc_top, recovery_data_memwrite_sel, data_recovery_sel,
    output recovery_busy, recovery_fail, fault_count
  );
endinterface

// File: rtl/pc_recovery_ctrl.sv
// Rollback controller: keeps the rd fields of the last DEPTH voted words and replays
// them as `lw rd,0(rd)` loads on a voter fault. `PC_RECOVERY_RD_FILTER_EN skips rd=0 entries.
module pc_recovery_ctrl #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int FCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  pc_recovery_ctrl_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REPLAY, S_CHECK, S_FAIL} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     retry_cnt_q, retry_cnt_d;
  logic [FCNT_W-1:0] fault_count_q, fault_count_d;

  // Only rd matters for the replayed load, so that is all the history keeps.
  logic [4:0]        hist_mem [DEPTH];
  logic              push;
  logic [DEPTH-1:0]  keep_vec;
  logic              found;
  logic              more;
  logic [PW-1:0]     sel_idx;
  logic [CW-1:0]     skip;
  logic [4:0]        sel_rd;
  logic [PW-1:0]     oldest;
  logic              voter_fault;
  logic              replay_drive;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_keep
`ifdef PC_RECOVERY_RD_FILTER_EN
      assign keep_vec[gi] = |hist_mem[gi];
`else
      assign keep_vec[gi] = 1'b1;
`endif
    end
  endgenerate

  assign voter_fault = (bus.voter_state == 3'b000);
  assign oldest      = wr_ptr_q - count_q[PW-1:0];

  // Scan-ahead over the not-yet-replayed entries: first kept one is output now,
  // 'more' tells whether another kept entry follows it in this pass.
  always_comb begin
    found   = 1'b0;
    more    = 1'b0;
    sel_idx = rd_ptr_q;
    skip    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < rem_q) && keep_vec[rd_ptr_q + PW'(i)]) begin
        if (!found) begin
          found   = 1'b1;
          sel_idx = rd_ptr_q + PW'(i);
          skip    = CW'(i);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rem_d         = rem_q;
    retry_cnt_d   = retry_cnt_q;
    fault_count_d = fault_count_q;
    push          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (voter_fault) begin
          if (fault_count_q != '1) fault_count_d = fault_count_q + FCNT_W'(1);
          retry_cnt_d = '0;
          rd_ptr_d    = oldest;
          rem_d       = count_q;
          state_d     = (count_q != '0) ? S_REPLAY : S_CHECK;
        end else if (bus.pc_valid) begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
        end
      end
      S_REPLAY: begin
        if (found) begin
          rd_ptr_d = sel_idx + PW'(1);
          rem_d    = rem_q - skip - CW'(1);
          if (!more) state_d = S_CHECK;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!voter_fault) begin
          state_d = S_IDLE;
        end else if (retry_cnt_q == RW'(MAX_RETRY - 1)) begin
          state_d = S_FAIL;
        end else begin
          retry_cnt_d = retry_cnt_q + RW'(1);
          rd_ptr_d    = oldest;
          rem_d       = count_q;
          state_d     = (count_q != '0) ? S_REPLAY : S_CHECK;
        end
      end
      default: state_d = S_FAIL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rem_q         <= '0;
      retry_cnt_q   <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      retry_cnt_q   <= retry_cnt_d;
      fault_count_q <= fault_count_d;
    end
  end

  // History storage needs no reset: count_q marks which entries are live.
  always_ff @(posedge clk) begin
    if (push) hist_mem[wr_ptr_q] <= bus.pc_voter_output[11:7];
  end

  assign sel_rd       = hist_mem[sel_idx];
  assign replay_drive = (state_q == S_REPLAY) && found;

  assign bus.pc_top = replay_drive
                    ? XLEN'({12'b0, sel_rd, 3'b010, sel_rd, 7'b0000011})
                    : bus.pc_voter_output;
  assign bus.recovery_data_memwrite_sel = replay_drive;
  assign bus.data_recovery_sel          = replay_drive;
  assign bus.recovery_busy              = (state_q == S_REPLAY) || (state_q == S_CHECK);
  assign bus.recovery_fail              = (state_q == S_FAIL);
  assign bus.fault_count                = fault_count_q;
endmodule

// File: tb/tb_pc_recovery_ctrl.sv
// Randomised bench for pc_recovery_ctrl against a queue-based model of the history
// and replay passes, plus literal expectations from the directed scenarios.
module tb_pc_recovery_ctrl;
  localparam int XLEN      = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 2;
  localparam int FCNT_W    = 8;
  localparam int FSAT      = (1 << FCNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_recovery_ctrl_if #(.XLEN(XLEN), .FCNT_W(FCNT_W)) bus ();

  pc_recovery_ctrl #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_REPLAY, P_CHECK, P_FAIL} phase_t;
  phase_t      ph = P_IDLE;
  logic [31:0] hist_q[$];
  logic [31:0] pend_q[$];
  int          retries = 0;
  int          fcnt = 0;

  function automatic logic [31:0] rw(logic [31:0] e);
    int rd;
    rd = (e >> 7) % 32;
    return (rd * 32768) + (2 * 4096) + (rd * 128) + 3;
  endfunction

  function automatic bit kept(logic [31:0] e);
`ifdef PC_RECOVERY_RD_FILTER_EN
    return ((e >> 7) % 32) != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic load_pass();
    pend_q = {};
    foreach (hist_q[i]) if (kept(hist_q[i])) pend_q.push_back(hist_q[i]);
    ph = (hist_q.size() > 0) ? P_REPLAY : P_CHECK;
  endtask

  task automatic model_step();
    case (ph)
      P_IDLE: begin
        if (bus.voter_state == 3'b000) begin
          if (fcnt < FSAT) fcnt++;
          retries = 0;
          load_pass();
        end else if (bus.pc_valid) begin
          hist_q.push_back(bus.pc_voter_output);
          if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
        end
      end
      P_REPLAY: begin
        if (pend_q.size() > 0) void'(pend_q.pop_front());
        if (pend_q.size() == 0) ph = P_CHECK;
      end
      P_CHECK: begin
        if (bus.voter_state != 3'b000) ph = P_IDLE;
        else if (retries == MAX_RETRY - 1) ph = P_FAIL;
        else begin
          retries++;
          load_pass();
        end
      end
      default: ph = P_FAIL;
    endcase
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE;
      hist_q = {};
      pend_q = {};
      retries = 0;
      fcnt = 0;
    end else begin
      model_step();
    end
  end

  // Single compare process against the model.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    logic        exp_sel;
    if (chk_en) begin
      if (ph == P_REPLAY && pend_q.size() > 0) begin
        exp_pc  = rw(pend_q[0]);
        exp_sel = 1'b1;
      end else begin
        exp_pc  = bus.pc_voter_output;
        exp_sel = 1'b0;
      end
      chk("m_pc_top", bus.pc_top, exp_pc);
      chk("m_memwrite_sel", bus.recovery_data_memwrite_sel, exp_sel);
      chk("m_data_sel", bus.data_recovery_sel, exp_sel);
      chk("m_busy", bus.recovery_busy, (ph == P_REPLAY || ph == P_CHECK));
      chk("m_fail", bus.recovery_fail, (ph == P_FAIL));
      chk("m_fault_count", bus.fault_count, fcnt);
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change at posedge+1; literal checks happen at posedge+3.
  task automatic cyc(input logic [2:0] vs, input logic [31:0] w, input logic v);
    @(posedge clk);
    #1;
    bus.voter_state     = vs;
    bus.pc_voter_output = w;
    bus.pc_valid        = v;
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.pc_valid    = 1'b0;
    bus.voter_state = 3'b111;
    #2;
    chk("rst_busy", bus.recovery_busy, 0);
    chk("rst_sel", bus.data_recovery_sel, 0);
    chk("rst_fail", bus.recovery_fail, 0);
    chk("rst_fcnt", bus.fault_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.voter_state     = 3'b111;
    bus.pc_voter_output = 32'h12345678;
    bus.pc_valid        = 1'b0;

    cyc(3'b111, 32'h12345678, 1'b0);
    chk_en = 1'b1;
    chk("rst_pc_top", bus.pc_top, 32'h12345678);
    chk("rst_busy0", bus.recovery_busy, 0);
    chk("rst_fcnt0", bus.fault_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic history and replay.
    cyc(3'b111, 32'h00A00093, 1'b1);
    chk("push_pass", bus.pc_top, 32'h00A00093);
    chk("push_sel", bus.data_recovery_sel, 0);
    cyc(3'b111, 32'h00B00113, 1'b1);
    cyc(3'b111, 32'h00C00193, 1'b1);
    cyc(3'b000, 32'hDEADBEEF, 1'b0);
    chk("detect_pass", bus.pc_top, 32'hDEADBEEF);
    chk("detect_busy", bus.recovery_busy, 0);
    cyc(3'b111, 32'h0, 1'b0);
    chk("replay0", bus.pc_top, 32'h0000A083);
    chk("replay0_sel", bus.recovery_data_memwrite_sel, 1);
    chk("replay0_busy", bus.recovery_busy, 1);
    cyc(3'b111, 32'h0, 1'b0);
    chk("replay1", bus.pc_top, 32'h00012103);
    cyc(3'b111, 32'h0, 1'b0);
    chk("replay2", bus.pc_top, 32'h0001A183);
    cyc(3'b111, 32'h00000055, 1'b0);
    chk("check_pass", bus.pc_top, 32'h00000055);
    chk("check_sel", bus.data_recovery_sel, 0);
    chk("check_busy", bus.recovery_busy, 1);
    cyc(3'b111, 32'h0, 1'b0);
    chk("idle_busy", bus.recovery_busy, 0);
    chk("fcnt1", bus.fault_count, 1);

    // Overwrite: six pushes, only rd=3..6 remain.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(3'b111, 32'h00000093 | ((i + 1) << 7), 1'b1);
    cyc(3'b000, 32'h0, 1'b0);
    cyc(3'b111, 32'h0, 1'b0);
    chk("wrap_first", bus.pc_top, 32'h0001A183);
    repeat (6) cyc(3'b111, 32'h0, 1'b0);

    // Reset in the middle of a replay pass, then fault on an empty history.
    cyc(3'b000, 32'h0, 1'b0);
    cyc(3'b111, 32'h0, 1'b0);
    cyc(3'b111, 32'h0, 1'b0);
    do_reset();
    cyc(3'b000, 32'h0, 1'b0);
    cyc(3'b111, 32'h00000077, 1'b0);
    chk("empty_check_busy", bus.recovery_busy, 1);
    chk("empty_check_sel", bus.data_recovery_sel, 0);
    chk("empty_check_pc", bus.pc_top, 32'h00000077);
    cyc(3'b111, 32'h0, 1'b0);
    chk("empty_idle", bus.recovery_busy, 0);

    // Persistent fault -> two passes then sticky failure.
    cyc(3'b111, 32'h00A00093, 1'b1);
    cyc(3'b111, 32'h00B00113, 1'b1);
    cyc(3'b111, 32'h00C00193, 1'b1);
    repeat (12) cyc(3'b000, 32'h0, 1'b0);
    chk("fail_set", bus.recovery_fail, 1);
    repeat (3) cyc(3'b111, 32'h0, 1'b1);
    chk("fail_sticky", bus.recovery_fail, 1);
    chk("fail_notbusy", bus.recovery_busy, 0);
    do_reset();

    // rd=0 entry handling.
    cyc(3'b111, 32'h00000013, 1'b1);
    cyc(3'b111, 32'h00A00093, 1'b1);
    cyc(3'b000, 32'h0, 1'b0);
    cyc(3'b111, 32'h0, 1'b0);
`ifdef PC_RECOVERY_RD_FILTER_EN
    chk("filt_word", bus.pc_top, 32'h0000A083);
    cyc(3'b111, 32'h0, 1'b0);
    chk("filt_check_sel", bus.data_recovery_sel, 0);
`else
    chk("nofilt_word0", bus.pc_top, 32'h00002003);
    cyc(3'b111, 32'h0, 1'b0);
    chk("nofilt_word1", bus.pc_top, 32'h0000A083);
`endif
    repeat (3) cyc(3'b111, 32'h0, 1'b0);

    // Fault counter saturation.
    do_reset();
    for (int i = 0; i < FSAT + 5; i++) begin
      cyc(3'b000, 32'h0, 1'b0);
      cyc(3'b111, 32'h0, 1'b0);
    end
    chk("fcnt_sat", bus.fault_count, FSAT);

    // Randomised traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      cyc(($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
          $urandom, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
